// File: rtl/vis_pkg.sv
// rtl/vis_pkg.sv - shared widths and FSM encoding for the centroid tracker
package vis_pkg;
    localparam int COORD_W = 11;
    localparam int AREA_W  = 22;
    localparam int SUM_W   = 33;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIV_X  = 2'd1,
        DIV_Y  = 2'd2,
        UPDATE = 2'd3
    } vis_state_e;
endpackage

// File: rtl/vis_centroid_ctrl_if.sv
// rtl/vis_centroid_ctrl_if.sv - video-in / centroid-out bundle for vis_centroid_ctrl
interface vis_centroid_ctrl_if;
    import vis_pkg::*;

    logic               de;
    logic               hsync;
    logic               vsync;
    logic               mask;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [AREA_W-1:0]  area;
    logic               centroid_valid;
    logic               busy;

    modport master (
        output de, hsync, vsync, mask,
        input  x, y, area, centroid_valid, busy
    );

    modport slave (
        input  de, hsync, vsync, mask,
        output x, y, area, centroid_valid, busy
    );
endinterface

// File: rtl/vis_div_seq.sv
// rtl/vis_div_seq.sv - restoring divider, one quotient bit per cycle over SUM_W cycles
module vis_div_seq
    import vis_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SUM_W-1:0]   dividend,
    input  logic [AREA_W-1:0]  divisor,
    output logic [COORD_W-1:0] quotient,
    output logic               done
);
    logic [SUM_W-1:0]  dvd_q;
    logic [SUM_W-1:0]  dvd_nx;
    logic [AREA_W-1:0] dsr_q;
    logic [AREA_W-1:0] rem_q;
    logic [AREA_W-1:0] rem_nx;
    logic [AREA_W:0]   rem_sh;
    logic [AREA_W:0]   diff;
    logic [CNT_W-1:0]  cnt_q;
    logic              ge;
    logic              unused_diff;

    // remainder stays below the divisor, so AREA_W bits always hold it
    always_comb begin
        rem_sh = {rem_q, dvd_q[SUM_W-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        ge     = (rem_sh >= {1'b0, dsr_q});
        rem_nx = ge ? diff[AREA_W-1:0] : rem_sh[AREA_W-1:0];
        dvd_nx = {dvd_q[SUM_W-2:0], ge};
    end

    assign unused_diff = diff[AREA_W];

    // done flags the final iteration; quotient is its combinational result
    assign done     = (cnt_q == CNT_W'(1));
    assign quotient = dvd_nx[COORD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            cnt_q <= CNT_W'(SUM_W);
        end else if (cnt_q != '0) begin
            dvd_q <= dvd_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end
endmodule

// File: rtl/vis_centroid_ctrl.sv
// rtl/vis_centroid_ctrl.sv - mask centroid tracker; VIS_CENTROID_MIN_AREA_EN gates updates on MIN_AREA
module vis_centroid_ctrl
    import vis_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int MIN_AREA = 16
) (
    input  logic clk,
    input  logic rst,
    vis_centroid_ctrl_if.slave vif
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_END  = COORD_W'(IMG_H);

    vis_state_e         state_q, state_d;
    logic               vsync_q;
    logic [COORD_W-1:0] x_pos, y_pos;
    logic [AREA_W-1:0]  m00, area_q;
    logic [SUM_W-1:0]   m10, m01, snap_m01;
    logic [COORD_W-1:0] qx_q, x_q, y_q;
    logic               frame_edge, upd_ok;
    logic               div_start, div_done;
    logic [SUM_W-1:0]   div_dividend;
    logic [AREA_W-1:0]  div_divisor;
    logic [COORD_W-1:0] div_quot;
    logic               unused_hsync;

    assign frame_edge   = vif.vsync & ~vsync_q;
    assign unused_hsync = vif.hsync;

    // area_q doubles as the snapshot of m00 for the whole division sequence
`ifdef VIS_CENTROID_MIN_AREA_EN
    assign upd_ok = (area_q >= AREA_W'(MIN_AREA));
`else
    localparam int MIN_AREA_UNUSED = MIN_AREA;
    assign upd_ok = (area_q != '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        div_start    = 1'b0;
        div_dividend = snap_m01;
        div_divisor  = area_q;
        case (state_q)
            ACCUM: begin
                if (frame_edge) begin
                    state_d      = DIV_X;
                    div_start    = 1'b1;
                    div_dividend = m10;
                    div_divisor  = m00;
                end
            end
            DIV_X: begin
                if (div_done) begin
                    state_d   = DIV_Y;
                    div_start = 1'b1;
                end
            end
            DIV_Y:   if (div_done) state_d = UPDATE;
            UPDATE:  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            x_pos    <= '0;
            y_pos    <= '0;
            m00      <= '0;
            m10      <= '0;
            m01      <= '0;
            area_q   <= '0;
            snap_m01 <= '0;
            qx_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            vsync_q <= vif.vsync;
            if (vif.vsync) begin
                x_pos <= '0;
                y_pos <= '0;
                m00   <= '0;
                m10   <= '0;
                m01   <= '0;
            end else if (vif.de) begin
                if (x_pos == X_LAST) begin
                    x_pos <= '0;
                    if (y_pos != '1) y_pos <= y_pos + COORD_W'(1);
                end else begin
                    x_pos <= x_pos + COORD_W'(1);
                end
                if (vif.mask && (y_pos < Y_END)) begin
                    m00 <= m00 + AREA_W'(1);
                    m10 <= m10 + SUM_W'(x_pos);
                    m01 <= m01 + SUM_W'(y_pos);
                end
            end
            if ((state_q == ACCUM) && frame_edge) begin
                area_q   <= m00;
                snap_m01 <= m01;
            end
            if ((state_q == DIV_X) && div_done) qx_q <= div_quot;
            // results land as UPDATE is entered so they align with the pulse
            if ((state_q == DIV_Y) && div_done && upd_ok) begin
                x_q <= qx_q;
                y_q <= div_quot;
            end
        end
    end

    vis_div_seq u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .done     (div_done)
    );

    assign vif.x              = x_q;
    assign vif.y              = y_q;
    assign vif.area           = area_q;
    assign vif.centroid_valid = (state_q == UPDATE) && upd_ok;
    assign vif.busy           = (state_q != ACCUM);
endmodule

// File: tb/tb_vis_centroid_ctrl.sv
// tb/tb_vis_centroid_ctrl.sv - directed self-checking bench for vis_centroid_ctrl
module tb_vis_centroid_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    vis_centroid_ctrl_if vif ();

    vis_centroid_ctrl #(
        .IMG_W    (64),
        .IMG_H    (64),
        .MIN_AREA (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // lines 64 and 65 are always mask=1 so out-of-frame pixels must be ignored
    function automatic logic mask_of(input int mode, input int px, input int py);
        if (py >= 64) return 1'b1;
        case (mode)
            1:       return (px == 10) && (py == 20);
            2:       return (px >= 8) && (px <= 15) && (py >= 4) && (py <= 7);
            3:       return 1'b1;
            4:       return (py == 1) && ((px == 1) || (px == 3) || (px == 5));
            5:       return ((px == 0) || (px == 2)) && ((py == 0) || (py == 2));
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_frame(input int mode);
        @(negedge clk);
        vif.vsync = 1'b0;
        vif.de    = 1'b0;
        vif.mask  = 1'b0;
        repeat (3) @(negedge clk);
        for (int ly = 0; ly < 66; ly++) begin
            for (int lx = 0; lx < 64; lx++) begin
                vif.de   = 1'b1;
                vif.mask = mask_of(mode, lx, ly);
                @(negedge clk);
            end
            vif.de    = 1'b0;
            vif.mask  = 1'b0;
            vif.hsync = 1'b1;
            @(negedge clk);
            vif.hsync = 1'b0;
            @(negedge clk);
        end
        vif.vsync = 1'b1;
    endtask

    task automatic check_result(input string tag, input logic ep, input int ex, input int ey,
                                input int ea, input bit second_edge);
        int early = 0;
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_busy_c1"}, 32'(vif.busy), 32'd1);
            if ((k < 67) && vif.centroid_valid) early++;
            if (k == 67) begin
                chk({tag, "_valid_c67"}, 32'(vif.centroid_valid), 32'(ep));
                chk({tag, "_x"}, 32'(vif.x), 32'(ex));
                chk({tag, "_y"}, 32'(vif.y), 32'(ey));
                chk({tag, "_area"}, 32'(vif.area), 32'(ea));
            end
            if (k == 68) begin
                chk({tag, "_valid_c68"}, 32'(vif.centroid_valid), 32'd0);
                chk({tag, "_busy_c68"}, 32'(vif.busy), 32'd0);
                chk({tag, "_early_pulses"}, 32'(early), 32'd0);
            end
            if (second_edge) begin
                vif.de    = (k >= 5) && (k < 30);
                vif.mask  = (k >= 5) && (k < 30);
                vif.vsync = !((k >= 5) && (k < 30));
            end
        end
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        vif.de    = 1'b0;
        vif.hsync = 1'b0;
        vif.vsync = 1'b0;
        vif.mask  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(vif.x), 32'd0);
        chk("rst_y", 32'(vif.y), 32'd0);
        chk("rst_area", 32'(vif.area), 32'd0);
        chk("rst_valid", 32'(vif.centroid_valid), 32'd0);
        chk("rst_busy", 32'(vif.busy), 32'd0);
        rst = 1'b0;

        drive_frame(1);
        check_result("single", 1'b1, 10, 20, 1, 1'b0);

        drive_frame(2);
        check_result("rect", 1'b1, 11, 5, 32, 1'b0);

        drive_frame(3);
        check_result("full", 1'b1, 31, 31, 4096, 1'b0);

        drive_frame(0);
        check_result("empty", 1'b0, 31, 31, 0, 1'b0);

        drive_frame(2);
        repeat (20) @(negedge clk);
        chk("mid_div_busy", 32'(vif.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_x", 32'(vif.x), 32'd0);
        chk("mid_rst_y", 32'(vif.y), 32'd0);
        chk("mid_rst_area", 32'(vif.area), 32'd0);
        chk("mid_rst_busy", 32'(vif.busy), 32'd0);
        chk("mid_rst_valid", 32'(vif.centroid_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (vif.centroid_valid) pulses++;
        end
        chk("post_rst_pulses", 32'(pulses), 32'd0);
        chk("post_rst_x", 32'(vif.x), 32'd0);

        drive_frame(1);
        check_result("dbl_edge", 1'b1, 10, 20, 1, 1'b1);

        drive_frame(4);
`ifdef VIS_CENTROID_MIN_AREA_EN
        check_result("three_px", 1'b0, 10, 20, 3, 1'b0);
`else
        check_result("three_px", 1'b1, 3, 1, 3, 1'b0);
`endif

        drive_frame(5);
        check_result("four_px", 1'b1, 1, 1, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
